// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 forms per-bit and per-group propagate/generate; stage 2 resolves carries and sums.
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / 4;

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;
    logic [NGRP-1:0]  s1_gp_q, s1_gp_d;
    logic [NGRP-1:0]  s1_gg_q, s1_gg_d;
    logic             s1_c0_q, s1_c0_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    logic             s2_cout_q, s2_cout_d;
    logic             s2_ovf_q, s2_ovf_d;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] bb, p_in, g_in;
    logic [NGRP-1:0]  gp_in, gg_in;
    logic [NGRP:0]    cg;
    logic [WIDTH:0]   c;

    // Stage 1 operand conditioning and group lookahead terms.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gp_in = '0;
        gg_in = '0;
        bb    = sub ? ~b : b;
        p_in  = a ^ bb;
        g_in  = a & bb;
        for (int k = 0; k < NGRP; k++) begin
            gp_in[k] = &p_in[4*k +: 4];
            gg_in[k] = g_in[4*k+3]
                     | (g_in[4*k+2] & p_in[4*k+3])
                     | (g_in[4*k+1] & p_in[4*k+3] & p_in[4*k+2])
                     | (g_in[4*k]   & p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1]);
        end
    end

    // Stage 2: group carries first, then the carries inside each group.
    always_comb begin
        cg    = '0;
        c     = '0;
        cg[0] = s1_c0_q;
        for (int k = 0; k < NGRP; k++) begin
            cg[k+1] = s1_gg_q[k] | (s1_gp_q[k] & cg[k]);
        end
        for (int k = 0; k < NGRP; k++) begin
            c[4*k] = cg[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = s1_g_q[4*k+i] | (s1_p_q[4*k+i] & c[4*k+i]);
            end
        end
        c[WIDTH] = cg[NGRP];
    end

    assign s2_load = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_fire = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p_d     = s1_p_q;
        s1_g_d     = s1_g_q;
        s1_gp_d    = s1_gp_q;
        s1_gg_d    = s1_gg_q;
        s1_c0_d    = s1_c0_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_cout_d  = s2_cout_q;
        s2_ovf_d   = s2_ovf_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_p_d     = p_in;
            s1_g_d     = g_in;
            s1_gp_d    = gp_in;
            s1_gg_d    = gg_in;
            s1_c0_d    = sub ? 1'b1 : cin;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_sum_d   = s1_p_q ^ c[WIDTH-1:0];
            s2_cout_d  = c[WIDTH];
            s2_ovf_d   = c[WIDTH-1] ^ c[WIDTH];
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
            s1_c0_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_g_q     <= s1_g_d;
            s1_gp_q    <= s1_gp_d;
            s1_gg_q    <= s1_gg_d;
            s1_c0_q    <= s1_c0_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_cout_q  <= s2_cout_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    // Handshakes are masked during reset so nothing transfers in the reset cycle.
    assign in_ready  = (!s1_valid_q || s2_load) && !rst;
    assign out_valid = s2_valid_q && !rst;
    assign sum       = s2_sum_q;
    assign cout      = s2_cout_q;
    assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed self-checking bench for cla_adder_pipe: WIDTH=16 main unit plus
// WIDTH=4 and WIDTH=64 instances for the full-ripple carry case.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_ready;

    logic        in_valid, in_ready, cin, sub, out_valid, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid_x;
    logic        in_ready4, out_valid4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;
    logic        in_ready64, out_valid64, cout64, ovf64;
    logic [63:0] a64, b64, sum64;

    int checks = 0;
    int errors = 0;

    cla_adder_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_adder_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(1'b1), .sub(1'b0), .out_valid(out_valid4),
        .out_ready(out_ready), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    cla_adder_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready64),
        .a(a64), .b(b64), .cin(1'b1), .sub(1'b0), .out_valid(out_valid64),
        .out_ready(out_ready), .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
    endtask

    logic [15:0] ra [8];
    logic [15:0] rb [8];
    logic        rc [8];
    logic [16:0] rexp [8];
    logic        rovf [8];
    logic [15:0] p0_sum, p1_sum, p2_sum;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        in_valid_x = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        a4  = 4'hF;
        b4  = 4'h0;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF;
        b64 = 64'h0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);

        // Test 1 (plus WIDTH=4/64 full ripple in parallel)
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        in_valid_x = 1'b1;
        check("t1_in_ready", 64'(in_ready), 64'd1);
        check("t6_in_ready64", 64'(in_ready64), 64'd1);
        tick();
        in_valid   = 1'b0;
        in_valid_x = 1'b0;
        check("t1_lat1_no_valid", 64'(out_valid), 64'd0);
        tick();
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_sum",       64'(sum),       64'h0000);
        check("t1_cout",      64'(cout),      64'd1);
        check("t1_ovf",       64'(ovf),       64'd0);
        check("t6_w4_valid",  64'(out_valid4), 64'd1);
        check("t6_w4_sum",    64'(sum4),       64'h0);
        check("t6_w4_cout",   64'(cout4),      64'd1);
        check("t6_w4_ovf",    64'(ovf4),       64'd0);
        check("t6_w64_valid", 64'(out_valid64), 64'd1);
        check("t6_w64_sum",   sum64,            64'h0);
        check("t6_w64_cout",  64'(cout64),      64'd1);
        check("t6_w64_in_ready4", 64'(in_ready4), 64'd1);
        tick();
        check("t1_drained", 64'(out_valid), 64'd0);

        // Test 2: signed overflow, then subtraction with borrow
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t2a_sum",  64'(sum),  64'h8000);
        check("t2a_cout", 64'(cout), 64'd0);
        check("t2a_ovf",  64'(ovf),  64'd1);
        tick();
        check("t2b_valid", 64'(out_valid), 64'd1);
        check("t2b_sum",   64'(sum),  64'hFFFE);
        check("t2b_cout",  64'(cout), 64'd0);
        check("t2b_ovf",   64'(ovf),  64'd0);
        tick();
        check("t2_drained", 64'(out_valid), 64'd0);

        // Test 3: 8 back-to-back random pairs at full throughput
        for (int i = 0; i < 8; i++) begin
            ra[i]   = 16'($urandom);
            rb[i]   = 16'($urandom);
            rc[i]   = 1'($urandom);
            rexp[i] = {1'b0, ra[i]} + {1'b0, rb[i]} + {16'b0, rc[i]};
            rovf[i] = (ra[i][15] == rb[i][15]) && (rexp[i][15] != ra[i][15]);
        end
        for (int t = 0; t < 10; t++) begin
            if (t >= 2) begin
                check("t3_valid", 64'(out_valid), 64'd1);
                check("t3_sum",   64'(sum),  64'(rexp[t-2][15:0]));
                check("t3_cout",  64'(cout), 64'(rexp[t-2][16]));
                check("t3_ovf",   64'(ovf),  64'(rovf[t-2]));
            end
            if (t < 8) begin
                drive(ra[t], rb[t], rc[t], 1'b0);
                check("t3_in_ready", 64'(in_ready), 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("t3_drained", 64'(out_valid), 64'd0);

        // Test 4: back-pressure with 3 pairs offered
        p0_sum = 16'h1111 + 16'h2222;
        p1_sum = 16'h4000 + 16'h0123 + 16'h0001;
        p2_sum = 16'h0100 - 16'h0001;
        out_ready = 1'b0;
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        check("t4_accept0", 64'(in_ready), 64'd1);
        tick();
        drive(16'h4000, 16'h0123, 1'b1, 1'b0);
        check("t4_accept1", 64'(in_ready), 64'd1);
        tick();
        drive(16'h0100, 16'h0001, 1'b0, 1'b1);
        check("t4_full_in_ready", 64'(in_ready), 64'd0);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_sum0",  64'(sum), 64'(p0_sum));
        tick();
        tick();
        check("t4_frozen_in_ready", 64'(in_ready), 64'd0);
        check("t4_frozen_valid", 64'(out_valid), 64'd1);
        check("t4_frozen_sum",   64'(sum), 64'(p0_sum));
        out_ready = 1'b1;
        #1;
        check("t4_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t4_sum1",  64'(sum), 64'(p1_sum));
        check("t4_valid1", 64'(out_valid), 64'd1);
        tick();
        check("t4_sum2",  64'(sum), 64'(p2_sum));
        check("t4_cout2", 64'(cout), 64'd1);
        tick();
        check("t4_drained", 64'(out_valid), 64'd0);

        // Test 5: reset with both stages full
        out_ready = 1'b0;
        drive(16'hABCD, 16'h1234, 1'b0, 1'b0);
        tick();
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t5_full_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rstcyc_valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t5_valid",    64'(out_valid), 64'd0);
        check("t5_in_ready", 64'(in_ready),  64'd1);
        check("t5_sum",      64'(sum),       64'd0);
        check("t5_cout",     64'(cout),      64'd0);
        tick();
        check("t5_no_stale1", 64'(out_valid), 64'd0);
        tick();
        check("t5_no_stale2", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
